// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Pass/fail monitor for the core's data-memory write bus. It snoops
//   mem_write / data_adr / write_data and latches a sticky verdict:
//   PASS on the signature store, FAIL on any store outside the scratch
//   window, and TIMEOUT when no verdict arrives within TIMEOUT_CYCLES RUN
//   cycles. It also keeps a few diagnostics about the run.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   run_en       arms the checker (IDLE -> RUN)
//   clear        synchronous return to IDLE; zeroes counters and diagnostics
//   mem_write    store strobe (only a clean 1 counts as a store)
//   data_adr     store address
//   write_data   store data
//   busy         checker is in RUN
//   done         a verdict is latched (PASS, FAIL or TIMEOUT)
//   pass         verdict is PASS
//   fail         verdict is FAIL
//   timeout      verdict is TIMEOUT
//   fail_addr    address of the offending store (FAIL only, else 0)
//   fail_data    data of the offending store (FAIL only, else 0)
//   cycle_count  RUN cycles elapsed (saturating)
//   store_count  tolerated scratch stores seen (saturating)
//
// State table
//   state     | meaning
//   S_IDLE    | bus ignored, waiting for run_en
//   S_RUN     | decoding stores, counting cycles toward timeout
//   S_PASS    | signature store seen (sticky)
//   S_FAIL    | store outside the scratch window seen (sticky)
//   S_TIMEOUT | no verdict within TIMEOUT_CYCLES RUN cycles (sticky)

module mem_write_checker #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [ADDR_W-1:0] PASS_ADDR  = ADDR_W'(100),
  parameter logic [DATA_W-1:0] PASS_DATA  = DATA_W'(25),
  parameter logic [ADDR_W-1:0] SCRATCH_LO = ADDR_W'(96),
  parameter logic [ADDR_W-1:0] SCRATCH_HI = ADDR_W'(96),
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic              clear,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  // Timeout fires on the edge where cycle_count already holds this value.
  // The compare is done at 32 bits so a narrow counter that saturates
  // below this value simply never times out instead of aliasing.
  localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cyc_nxt, stc_nxt;
  logic [ADDR_W-1:0] fa_nxt;
  logic [DATA_W-1:0] fd_nxt;
  logic              terminal;
  logic              to_hit;
  logic              cyc_sat, stc_sat;

  assign to_hit  = (32'(cycle_count) == TO_LAST);
  assign cyc_sat = (cycle_count == {CNT_W{1'b1}});
  assign stc_sat = (store_count == {CNT_W{1'b1}});

  // Next-state / next-diagnostics.
  // The store decode is written as an if/else chain on purpose: an X on
  // mem_write makes the outer if false (no store), and an X on the address
  // or data compares falls through both equality tests into the FAIL
  // branch, so unknown bus values can never produce a PASS.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cycle_count;
    stc_nxt   = store_count;
    fa_nxt    = fail_addr;
    fd_nxt    = fail_data;
    terminal  = 1'b0;

    if (clear) begin
      state_nxt = S_IDLE;
      cyc_nxt   = '0;
      stc_nxt   = '0;
      fa_nxt    = '0;
      fd_nxt    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_en) begin
            state_nxt = S_RUN;
            cyc_nxt   = '0;
            stc_nxt   = '0;
          end
        end

        S_RUN: begin
          if (mem_write) begin
            if ((data_adr == PASS_ADDR) && (write_data == PASS_DATA)) begin
              state_nxt = S_PASS;
              terminal  = 1'b1;
            end else if ((data_adr >= SCRATCH_LO) && (data_adr <= SCRATCH_HI)) begin
              if (!stc_sat) begin
                stc_nxt = store_count + 1'b1;
              end
            end else begin
              state_nxt = S_FAIL;
              fa_nxt    = data_adr;
              fd_nxt    = write_data;
              terminal  = 1'b1;
            end
          end

          // A terminal store beats the timeout on the same edge. The counter
          // only advances on edges that stay in RUN, so it holds the value
          // it had when the verdict was taken.
          if (!terminal) begin
            if (to_hit) begin
              state_nxt = S_TIMEOUT;
            end else if (!cyc_sat) begin
              cyc_nxt = cycle_count + 1'b1;
            end
          end
        end

        S_PASS, S_FAIL, S_TIMEOUT: begin
          state_nxt = state;
        end

        default: begin
          state_nxt = S_IDLE;
          cyc_nxt   = '0;
          stc_nxt   = '0;
          fa_nxt    = '0;
          fd_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Status flags are registered from the next state so they come straight
  // out of flops rather than through a state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      cycle_count <= '0;
      store_count <= '0;
    end else begin
      busy        <= (state_nxt == S_RUN);
      done        <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) ||
                     (state_nxt == S_TIMEOUT);
      pass        <= (state_nxt == S_PASS);
      fail        <= (state_nxt == S_FAIL);
      timeout     <= (state_nxt == S_TIMEOUT);
      fail_addr   <= fa_nxt;
      fail_data   <= fd_nxt;
      cycle_count <= cyc_nxt;
      store_count <= stc_nxt;
    end
  end

endmodule
